// File: rtl/traffic_sensor_frontend_if.sv
// Sensor/lamp interface between the loop-detector front end and its environment.
// The frontend takes the slave side; the driving environment takes the master side.
interface traffic_sensor_frontend_if #(
  parameter int QW = 4
);
  logic          loop_ns;
  logic          loop_ew;
  logic          Gns;
  logic          Yns;
  logic          Rns;
  logic          Gew;
  logic          Yew;
  logic          Rew;
  logic          fault_clr;
  logic          ns_sensor;
  logic          ew_sensor;
  logic [QW-1:0] ns_queue;
  logic [QW-1:0] ew_queue;
  logic          fault;

  modport master (
    output loop_ns, loop_ew, Gns, Yns, Rns, Gew, Yew, Rew, fault_clr,
    input  ns_sensor, ew_sensor, ns_queue, ew_queue, fault
  );

  modport slave (
    input  loop_ns, loop_ew, Gns, Yns, Rns, Gew, Yew, Rew, fault_clr,
    output ns_sensor, ew_sensor, ns_queue, ew_queue, fault
  );
endinterface

// File: rtl/traffic_sensor_frontend.sv
// Loop-detector conditioning (sync, debounce, request latch, queue count) for
// both approaches, plus a sticky lamp-conflict monitor with post-reset holdoff.
module traffic_sensor_frontend #(
  parameter int DEBOUNCE = 4,
  parameter int QW       = 4,
  parameter int HOLDOFF  = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  traffic_sensor_frontend_if.slave bus
);

  localparam logic [7:0]    DB_LIM = 8'(DEBOUNCE);
  localparam logic [7:0]    HO_LIM = 8'(HOLDOFF);
  localparam logic [QW-1:0] Q_MAX  = {QW{1'b1}};
  localparam logic [QW-1:0] Q_ONE  = QW'(1);

  // Index 0 is NS, index 1 is EW.
  logic [1:0]    loop_s;
  logic [1:0]    green_s;
  logic [1:0]    s1_r;
  logic [1:0]    s2_r;
  logic [1:0]    filt_r;
  logic [1:0]    filt_d_r;
  logic [1:0]    arrival_s;
  logic [1:0]    sensor_r;
  logic [7:0]    cnt_r   [2];
  logic [QW-1:0] queue_r [2];
  logic [7:0]    hold_r;
  logic          check_en_s;
  logic          violation_s;
  logic          fault_r;

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  assign loop_s  = {bus.loop_ew, bus.loop_ns};
  assign green_s = {bus.Gew, bus.Gns};

  // Two-flop synchroniser and debounce filter per approach
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r     <= 2'b00;
      s2_r     <= 2'b00;
      filt_r   <= 2'b00;
      filt_d_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= 8'd0;
      end
    end else begin
      s1_r     <= loop_s;
      s2_r     <= s1_r;
      filt_d_r <= filt_r;
      for (int i = 0; i < 2; i++) begin
        if (s2_r[i] != filt_r[i]) begin
          if ((cnt_r[i] + 8'd1) == DB_LIM) begin
            filt_r[i] <= s2_r[i];
            cnt_r[i]  <= 8'd0;
          end else begin
            cnt_r[i]  <= cnt_r[i] + 8'd1;
          end
        end else begin
          cnt_r[i] <= 8'd0;
        end
      end
    end
  end

  // Rising edge of the filtered level marks one vehicle arrival
  always_comb begin
    arrival_s = filt_r & ~filt_d_r;
  end

  // Request latch and saturating queue; green clears and wins over an arrival
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensor_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        queue_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (green_s[i]) begin
          sensor_r[i] <= 1'b0;
          queue_r[i]  <= '0;
        end else if (arrival_s[i]) begin
          sensor_r[i] <= 1'b1;
          queue_r[i]  <= (queue_r[i] == Q_MAX) ? queue_r[i] : queue_r[i] + Q_ONE;
        end else begin
          sensor_r[i] <= sensor_r[i];
          queue_r[i]  <= queue_r[i];
        end
      end
    end
  end

  // Holdoff counter: lamps are not trusted until the controller has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 8'd0;
    end else if (hold_r != HO_LIM) begin
      hold_r <= hold_r + 8'd1;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Lamp conflict: a non-one-hot head, or both approaches not red at once
  always_comb begin
    check_en_s  = (hold_r == HO_LIM);
    violation_s = check_en_s &&
                  (!onehot3({bus.Gns, bus.Yns, bus.Rns}) ||
                   !onehot3({bus.Gew, bus.Yew, bus.Rew}) ||
                   (!bus.Rns && !bus.Rew));
  end

  // Sticky fault flag; a new violation beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (violation_s) begin
      fault_r <= 1'b1;
    end else if (bus.fault_clr) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign bus.ns_sensor = sensor_r[0];
  assign bus.ew_sensor = sensor_r[1];
  assign bus.ns_queue  = queue_r[0];
  assign bus.ew_queue  = queue_r[1];
  assign bus.fault     = fault_r;

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Directed bench for traffic_sensor_frontend: a vector table for the basic
// request latency, then hand-written sequences for the multi-cycle corners.
module tb_traffic_sensor_frontend;

  localparam int QW = 4;

  // Lamp codes as {Gns,Yns,Rns,Gew,Yew,Rew}
  localparam logic [5:0] L_NSR_EWG = 6'b001100;
  localparam logic [5:0] L_NSG_EWR = 6'b100001;
  localparam logic [5:0] L_BOTH_G  = 6'b100100;
  localparam logic [5:0] L_NS_DARK = 6'b000001;
  localparam logic [5:0] L_ALL_OFF = 6'b000000;

  typedef struct {
    logic          loop_ns;
    logic [5:0]    lamps;
    logic          e_ns_s;
    logic [QW-1:0] e_ns_q;
    logic          e_ew_s;
    logic [QW-1:0] e_ew_q;
    logic          e_fault;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  traffic_sensor_frontend_if #(.QW(QW)) bus ();

  traffic_sensor_frontend #(
    .DEBOUNCE (4),
    .QW       (QW),
    .HOLDOFF  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic [5:0] l);
    {bus.Gns, bus.Yns, bus.Rns, bus.Gew, bus.Yew, bus.Rew} = l;
  endtask

  initial begin
    vec_t vecs [16];

    total  = 0;
    passed = 0;

    // Loop NS held high from edge 1: request appears at edge 7, falling edge
    // of the loop later produces no further event.
    vecs[0]  = '{1'b1, L_NSR_EWG, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, L_NSR_EWG, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, L_NSR_EWG, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[3]  = '{1'b1, L_NSR_EWG, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[4]  = '{1'b1, L_NSR_EWG, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[5]  = '{1'b1, L_NSR_EWG, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[7]  = '{1'b1, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[8]  = '{1'b1, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[9]  = '{1'b0, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[10] = '{1'b0, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[11] = '{1'b0, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[12] = '{1'b0, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[13] = '{1'b0, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[14] = '{1'b0, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};
    vecs[15] = '{1'b0, L_NSR_EWG, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0};

    rst_n         = 1'b0;
    bus.loop_ns   = 1'b0;
    bus.loop_ew   = 1'b0;
    bus.fault_clr = 1'b0;
    set_lamps(L_NSR_EWG);
    tick();
    tick();
    chk("rst_ns_sensor", 32'(bus.ns_sensor), 32'd0);
    chk("rst_ew_sensor", 32'(bus.ew_sensor), 32'd0);
    chk("rst_ns_queue",  32'(bus.ns_queue),  32'd0);
    chk("rst_ew_queue",  32'(bus.ew_queue),  32'd0);
    chk("rst_fault",     32'(bus.fault),     32'd0);
    rst_n = 1'b1;

    // Table: vector i is applied before edge i+1 and checked just after it
    for (int i = 0; i < 16; i++) begin
      bus.loop_ns = vecs[i].loop_ns;
      set_lamps(vecs[i].lamps);
      tick();
      chk($sformatf("vec%0d_ns_sensor", i), 32'(bus.ns_sensor), 32'(vecs[i].e_ns_s));
      chk($sformatf("vec%0d_ns_queue", i),  32'(bus.ns_queue),  32'(vecs[i].e_ns_q));
      chk($sformatf("vec%0d_ew_sensor", i), 32'(bus.ew_sensor), 32'(vecs[i].e_ew_s));
      chk($sformatf("vec%0d_ew_queue", i),  32'(bus.ew_queue),  32'(vecs[i].e_ew_q));
      chk($sformatf("vec%0d_fault", i),     32'(bus.fault),     32'(vecs[i].e_fault));
    end

    // EW glitch rejection (3 cycles) then a long-enough pulse (6 cycles)
    set_lamps(L_NSG_EWR);
    bus.loop_ew = 1'b1;
    repeat (3) tick();
    bus.loop_ew = 1'b0;
    repeat (10) tick();
    chk("glitch_ew_sensor", 32'(bus.ew_sensor), 32'd0);
    chk("glitch_ew_queue",  32'(bus.ew_queue),  32'd0);
    chk("gns_clears_ns_sensor", 32'(bus.ns_sensor), 32'd0);
    chk("gns_clears_ns_queue",  32'(bus.ns_queue),  32'd0);
    bus.loop_ew = 1'b1;
    repeat (6) tick();
    bus.loop_ew = 1'b0;
    repeat (10) tick();
    chk("pulse6_ew_sensor", 32'(bus.ew_sensor), 32'd1);
    chk("pulse6_ew_queue",  32'(bus.ew_queue),  32'd1);

    // 20 clean NS pulses under EW green: queue saturates at 15, no wrap
    set_lamps(L_NSR_EWG);
    for (int p = 0; p < 20; p++) begin
      bus.loop_ns = 1'b1;
      repeat (8) tick();
      bus.loop_ns = 1'b0;
      repeat (8) tick();
      chk($sformatf("sat_ns_queue_p%0d", p), 32'(bus.ns_queue), (p < 15) ? 32'(p + 1) : 32'd15);
      chk($sformatf("sat_ns_sensor_p%0d", p), 32'(bus.ns_sensor), 32'd1);
    end
    chk("gew_clears_ew_sensor", 32'(bus.ew_sensor), 32'd0);
    chk("gew_clears_ew_queue",  32'(bus.ew_queue),  32'd0);

    // NS green arrives on the same edge as a new NS arrival: green wins
    bus.loop_ns = 1'b1;
    repeat (6) tick();
    chk("pre_green_ns_sensor", 32'(bus.ns_sensor), 32'd1);
    chk("pre_green_ns_queue",  32'(bus.ns_queue),  32'd15);
    set_lamps(L_NSG_EWR);
    tick();
    chk("green_vs_arrival_sensor", 32'(bus.ns_sensor), 32'd0);
    chk("green_vs_arrival_queue",  32'(bus.ns_queue),  32'd0);
    bus.loop_ns = 1'b0;
    repeat (10) tick();
    bus.loop_ns = 1'b1;
    repeat (10) tick();
    chk("green_hold_ns_sensor", 32'(bus.ns_sensor), 32'd0);
    chk("green_hold_ns_queue",  32'(bus.ns_queue),  32'd0);
    bus.loop_ns = 1'b0;

    // Fault set by both greens, held, cleared, and set wins over clear
    chk("no_fault_legal", 32'(bus.fault), 32'd0);
    set_lamps(L_BOTH_G);
    tick();
    chk("fault_both_green", 32'(bus.fault), 32'd1);
    set_lamps(L_NSG_EWR);
    repeat (3) tick();
    chk("fault_sticky", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1'b1;
    tick();
    chk("fault_cleared", 32'(bus.fault), 32'd0);
    set_lamps(L_NS_DARK);
    tick();
    chk("fault_set_beats_clr", 32'(bus.fault), 32'd1);
    set_lamps(L_NSG_EWR);
    tick();
    bus.fault_clr = 1'b0;
    chk("fault_cleared_again", 32'(bus.fault), 32'd0);

    // Holdoff: all lamps dark right after reset only faults at edge 9
    rst_n = 1'b0;
    set_lamps(L_ALL_OFF);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("holdoff_edge%0d_fault", e), 32'(bus.fault), 32'd0);
    end
    tick();
    chk("holdoff_edge9_fault", 32'(bus.fault), 32'd1);

    // Async reset mid-request clears request, queue and fault without a clock
    set_lamps(L_NSR_EWG);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("pre_async_fault_clr", 32'(bus.fault), 32'd0);
    bus.loop_ns = 1'b1;
    repeat (8) tick();
    set_lamps(L_ALL_OFF);
    tick();
    set_lamps(L_NSR_EWG);
    chk("pre_async_ns_sensor", 32'(bus.ns_sensor), 32'd1);
    chk("pre_async_ns_queue",  32'(bus.ns_queue),  32'd1);
    chk("pre_async_fault",     32'(bus.fault),     32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ns_sensor", 32'(bus.ns_sensor), 32'd0);
    chk("async_ns_queue",  32'(bus.ns_queue),  32'd0);
    chk("async_fault",     32'(bus.fault),     32'd0);
    tick();
    rst_n = 1'b1;
    bus.loop_ns = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_frontend.md
Name: traffic_sensor_frontend

Overview:
- Front end that generates the `ns_sensor` / `ew_sensor` request inputs for the intersection controller.
- Conditions raw inductive-loop detector inputs:
  - synchronises them;
  - debounces them;
  - latches each vehicle arrival as a pending request until that approach's green lamp is seen.
- Observes the controller's six lamp outputs, so it is the closing end of the sensor/lamp interface.
- Per-approach queue counts and a sticky lamp-conflict fault flag go to the maintenance/status logic.

Parameters:
- DEBOUNCE, 4, consecutive clk cycles the synchronised loop level must differ from the filtered level before the filtered level changes (legal range 1..255).
- QW, 4, width of each queue counter.
- HOLDOFF, 8, clk cycles after reset release during which lamp fault checking is disabled (legal range 1..255).

Ports:
- clk  input  1  system clock (same clock that drives the controller's clock divider).
- rst_n  input  1  asynchronous active-low reset.
- loop_ns  input  1  raw NS loop detector, asynchronous to clk.
- loop_ew  input  1  raw EW loop detector, asynchronous to clk.
- Gns, Yns, Rns  input  1 each  NS lamp states from the controller.
- Gew, Yew, Rew  input  1 each  EW lamp states from the controller.
- fault_clr  input  1  synchronous clear of `fault`.
- ns_sensor  output  1  NS request pending, to the controller.
- ew_sensor  output  1  EW request pending, to the controller.
- ns_queue  output  QW  arrivals on NS since the last NS green.
- ew_queue  output  QW  arrivals on EW since the last EW green.
- fault  output  1  sticky lamp-conflict flag.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following go to 0:
  - sync flops, debounce counters, filtered levels;
  - `ns_sensor`, `ew_sensor`, `ns_queue`, `ew_queue`, `fault`;
  - holdoff counter.
- Reset asserted mid-operation clears everything immediately, including pending requests and sticky `fault`.
- Each approach X (ns, ew) is an identical independent channel:
  - Synchroniser: two flops, s1 <= loop_x, s2 <= s1.
  - Debounce:
    - `cnt` is 8 bits.
    - If s2 != filt: cnt increments; when cnt+1 == DEBOUNCE, filt <= s2 and cnt <= 0.
    - If s2 == filt: cnt <= 0. A glitch shorter than DEBOUNCE cycles is therefore rejected.
  - Arrival event: combinational pulse, high for exactly one cycle when filt goes 0->1 (filt high, filt_d low). A falling edge produces no event.
- Request latch (`x_sensor`), evaluated at each clk edge:
  - If Gx == 1: `x_sensor` <= 0 and `x_queue` <= 0. Green wins over a simultaneous arrival; the vehicle proceeds without a request.
  - Else, if arrival: `x_sensor` <= 1, and `x_queue` <= `x_queue` + 1, saturating at 2^QW-1 (no wrap).
  - Otherwise both hold.
- Latency: a clean loop rising edge first sampled at edge 1 gives filt high at edge DEBOUNCE+2 and `x_sensor` high at edge DEBOUNCE+3 (7 edges with defaults).
- While Gx is held high, further arrivals are ignored: no request, and the queue stays 0.
- Fault checking:
  - Holdoff counter counts clk cycles from reset release up to HOLDOFF, then saturates.
  - Checking is enabled once the counter equals HOLDOFF.
  - Violation (evaluated when enabled):
    - {Gns,Yns,Rns} not exactly one-hot; or
    - {Gew,Yew,Rew} not exactly one-hot; or
    - Rns == 0 and Rew == 0 together.
  - A violation sets `fault` at the next edge. `fault` stays set until fault_clr is sampled high.
  - Violation and fault_clr at the same edge: set wins.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Defaults; rst_n release, lamps Rns=1/Gew=1, loop_ns held high from edge 1 -> ns_sensor 0 through edge 6, 1 at edge 7; ns_queue == 1.
- loop_ew pulses high for 3 cycles with Gns=1/Rew=1 -> filt_ew never rises; ew_sensor and ew_queue stay 0. Repeat with a 6-cycle pulse -> ew_sensor 1, ew_queue 1.
- With Gew=1 and NS red, 20 separate clean NS loop pulses (each 8 high, 8 low) -> ns_queue saturates at 15; no wrap to 0; ns_sensor stays 1.
- Pending NS request, then lamps switch to Gns=1/Rew=1 on the same edge as a new NS arrival -> ns_sensor 0 and ns_queue 0 after that edge; both stay 0 while Gns holds.
- After holdoff, drive Gns=1 and Gew=1 with Rns=Rew=0 for one cycle -> fault 1 next edge and held. Assert fault_clr with legal lamps -> fault 0. Assert fault_clr together with a violation -> fault stays 1.
- All lamps 0 during the first 8 cycles after reset -> fault stays 0. All lamps 0 at cycle 9 -> fault 1. Async rst_n pulse mid-request -> ns_sensor, ns_queue and fault 0 immediately, without waiting for a clk edge.
